// File: rtl/beat_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : beat_sequencer_if
// Description : Control/status bundle between the beat-rate clock divider and
//               player control (master side) and the beat_sequencer (slave).
//               Master drives the beat tick, play/slow/reverse/loop levels,
//               stop and seek pulses, seek target and track length; slave
//               returns the current beat index and the status flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface beat_sequencer_if #(
  parameter int WIDTH = 12
);
  logic             beat_en;
  logic             play;
  logic             slow;
  logic             reverse;
  logic             loop;
  logic             stop;
  logic             seek_valid;
  logic [WIDTH-1:0] seek_beat;
  logic [WIDTH-1:0] len;
  logic [WIDTH-1:0] ibeat;
  logic             playing;
  logic             wrap;
  logic             done;

  modport master (
    output beat_en, play, slow, reverse, loop, stop, seek_valid, seek_beat, len,
    input  ibeat, playing, wrap, done
  );

  modport slave (
    input  beat_en, play, slow, reverse, loop, stop, seek_valid, seek_beat, len,
    output ibeat, playing, wrap, done
  );
endinterface
`default_nettype wire

// File: rtl/beat_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : beat_sequencer
// Description : Beat-index sequencer for the score ROM address. Advances the
//               beat index once per qualified beat tick (or once every
//               SLOW_DIV ticks in slow mode), forward or in reverse, looping
//               or stopping at the track ends. Supports seek and stop.
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous active-low reset
//               bus   - beat_sequencer_if slave: controls in, ibeat/status out
// Revision    : 1.0 - initial release
// ============================================================================
module beat_sequencer #(
  parameter int WIDTH    = 12,
  parameter int SLOW_DIV = 2
) (
  input  logic               clk,
  input  logic               reset,
  beat_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int                    c_presc_w   = $clog2(SLOW_DIV);
  localparam logic [c_presc_w-1:0]  c_presc_max = c_presc_w'(SLOW_DIV - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WIDTH-1:0]      r_ibeat;
  logic [WIDTH-1:0]      w_ibeat_nxt;
  logic [c_presc_w-1:0]  r_presc;
  logic [c_presc_w-1:0]  w_presc_nxt;
  logic                  r_playing;
  logic                  r_wrap;
  logic                  r_done;
  logic                  w_wrap_nxt;
  logic                  w_done_nxt;
  logic                  w_step;
  logic [WIDTH-1:0]      w_len_eff;
  logic [WIDTH-1:0]      w_last;
  logic [WIDTH-1:0]      w_seek_clamped;

  // A zero length behaves as a one-beat track, so LAST never underflows.
  always_comb begin
    w_len_eff      = (bus.len == '0) ? WIDTH'(1) : bus.len;
    w_last         = w_len_eff - WIDTH'(1);
    w_seek_clamped = (bus.seek_beat > w_last) ? w_last : bus.seek_beat;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ibeat_nxt = r_ibeat;
    // Prescaler only accumulates in slow mode; otherwise it stays cleared.
    w_presc_nxt = bus.slow ? r_presc : '0;
    w_wrap_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_step      = 1'b0;

    if (bus.stop) begin
      w_state_nxt = S_IDLE;
      w_ibeat_nxt = '0;
      w_presc_nxt = '0;
    end else if (bus.seek_valid) begin
      w_state_nxt = bus.play ? S_RUN : S_PAUSE;
      w_ibeat_nxt = w_seek_clamped;
      w_presc_nxt = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.play) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          // play dropping together with beat_en pauses without stepping.
          if (!bus.play) begin
            w_state_nxt = S_PAUSE;
          end else if (bus.beat_en) begin
            if (!bus.slow) begin
              w_step = 1'b1;
            end else if (r_presc == c_presc_max) begin
              w_step      = 1'b1;
              w_presc_nxt = '0;
            end else begin
              w_presc_nxt = r_presc + c_presc_w'(1);
            end
          end
        end
        S_PAUSE: begin
          if (bus.play) w_state_nxt = S_RUN;
        end
        S_DONE: begin
          // Leaves only through stop or seek, handled above.
        end
        default: w_state_nxt = S_IDLE;
      endcase

      if (w_step) begin
        if (!bus.reverse) begin
          // ibeat can sit above LAST after len shrinks; treat as end-of-track.
          if (r_ibeat < w_last) begin
            w_ibeat_nxt = r_ibeat + WIDTH'(1);
          end else if (bus.loop) begin
            w_ibeat_nxt = '0;
            w_wrap_nxt  = 1'b1;
          end else begin
            w_ibeat_nxt = w_last;
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          if (r_ibeat > w_last) begin
            // Out of range after a len shrink: snap to the end, no pulse.
            w_ibeat_nxt = w_last;
          end else if (r_ibeat != '0) begin
            w_ibeat_nxt = r_ibeat - WIDTH'(1);
          end else if (bus.loop) begin
            w_ibeat_nxt = w_last;
            w_wrap_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ibeat   <= '0;
      r_presc   <= '0;
      r_playing <= 1'b0;
      r_wrap    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ibeat   <= w_ibeat_nxt;
      r_presc   <= w_presc_nxt;
      r_playing <= (w_state_nxt == S_RUN);
      r_wrap    <= w_wrap_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign bus.ibeat   = r_ibeat;
  assign bus.playing = r_playing;
  assign bus.wrap    = r_wrap;
  assign bus.done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_beat_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_beat_sequencer
// Description : Self-checking bench for beat_sequencer. A driver applies
//               directed and random stimulus on the falling edge, runs a
//               behavioural player model and queues the expected outputs; a
//               monitor pops and compares after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beat_sequencer;

  localparam int W  = 12;
  localparam int SD = 2;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  typedef struct {
    int ibeat;
    int playing;
    int wrap;
    int done;
  } exp_t;

  logic clk;
  logic reset;

  beat_sequencer_if #(.WIDTH(W)) bus();

  beat_sequencer #(.WIDTH(W), .SLOW_DIV(SD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];

  // Level controls held by the stimulus; applied at each falling edge.
  logic         v_reset   = 1'b0;
  logic         v_play    = 1'b0;
  logic         v_slow    = 1'b0;
  logic         v_reverse = 1'b0;
  logic         v_loop    = 1'b0;
  logic [W-1:0] v_len     = W'(4);

  // Reference player state.
  int m_state = M_IDLE;
  int m_beat  = 0;
  int m_ticks = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_beat  = 0;
    m_ticks = 0;
  endtask

  // Computes what the player shows after the coming rising edge.
  task automatic model_eval(output exp_t e);
    int  last;
    int  wr;
    int  dn;
    bit  advance;
    wr = 0;
    dn = 0;
    advance = 0;
    last = ((bus.len == 0) ? 1 : int'(bus.len)) - 1;
    if (!reset) begin
      model_reset();
    end else if (bus.stop) begin
      model_reset();
    end else if (bus.seek_valid) begin
      m_beat  = (int'(bus.seek_beat) < last) ? int'(bus.seek_beat) : last;
      m_ticks = 0;
      m_state = bus.play ? M_RUN : M_PAUSE;
    end else begin
      if (!bus.slow) m_ticks = 0;
      if (m_state == M_IDLE || m_state == M_PAUSE) begin
        if (bus.play) m_state = M_RUN;
      end else if (m_state == M_RUN) begin
        if (!bus.play) m_state = M_PAUSE;
        else if (bus.beat_en) begin
          if (!bus.slow) advance = 1;
          else begin
            m_ticks = m_ticks + 1;
            if (m_ticks == SD) begin
              m_ticks = 0;
              advance = 1;
            end
          end
        end
      end
      if (advance) begin
        if (!bus.reverse) begin
          if (m_beat < last) m_beat++;
          else if (bus.loop) begin m_beat = 0; wr = 1; end
          else begin m_beat = last; m_state = M_DONE; dn = 1; end
        end else begin
          if (m_beat > last) m_beat = last;
          else if (m_beat > 0) m_beat--;
          else if (bus.loop) begin m_beat = last; wr = 1; end
          else begin m_state = M_DONE; dn = 1; end
        end
      end
    end
    e.ibeat   = m_beat;
    e.playing = (m_state == M_RUN) ? 1 : 0;
    e.wrap    = wr;
    e.done    = dn;
  endtask

  task automatic cyc(input logic be, input logic st, input logic sk,
                     input logic [W-1:0] sb);
    exp_t e;
    @(negedge clk);
    reset          = v_reset;
    bus.play       = v_play;
    bus.slow       = v_slow;
    bus.reverse    = v_reverse;
    bus.loop       = v_loop;
    bus.len        = v_len;
    bus.beat_en    = be;
    bus.stop       = st;
    bus.seek_valid = sk;
    bus.seek_beat  = sb;
    model_eval(e);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic beats(input int n, input int gap);
    repeat (n) begin
      cyc(1'b1, 1'b0, 1'b0, '0);
      idle(gap - 1);
    end
  endtask

  task automatic seek(input int b);
    cyc(1'b0, 1'b0, 1'b1, W'(b));
  endtask

  // Reset asserted between clock edges must clear outputs without a clock.
  task automatic mid_reset();
    @(posedge clk);
    #3;
    v_reset = 1'b0;
    reset   = 1'b0;
    model_reset();
    #1;
    check("async_rst_ibeat",   int'(bus.ibeat),   0);
    check("async_rst_playing", int'(bus.playing), 0);
    check("async_rst_wrap",    int'(bus.wrap),    0);
    check("async_rst_done",    int'(bus.done),    0);
  endtask

  // Monitor: compares every queued expectation once the edge has settled.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ibeat",   int'(bus.ibeat),   e.ibeat);
        check("playing", int'(bus.playing), e.playing);
        check("wrap",    int'(bus.wrap),    e.wrap);
        check("done",    int'(bus.done),    e.done);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset          = 1'b0;
    bus.beat_en    = 1'b0;
    bus.play       = 1'b0;
    bus.slow       = 1'b0;
    bus.reverse    = 1'b0;
    bus.loop       = 1'b0;
    bus.stop       = 1'b0;
    bus.seek_valid = 1'b0;
    bus.seek_beat  = '0;
    bus.len        = W'(4);

    // Reset state.
    idle(3);
    v_reset = 1'b1;
    idle(2);

    // Forward loop over a 4-beat track.
    v_len = W'(4); v_loop = 1'b1; v_play = 1'b1;
    idle(1);
    beats(5, 3);

    // One-shot end; play toggles and ticks ignored in DONE; seek restarts.
    cyc(1'b0, 1'b1, 1'b0, '0);
    v_len = W'(3); v_loop = 1'b0;
    idle(1);
    beats(4, 3);
    v_play = 1'b0; beats(2, 2);
    v_play = 1'b1; beats(2, 2);
    seek(0);
    beats(2, 2);

    // Slow reverse loop on a 5-beat track.
    v_len = W'(5); v_slow = 1'b1; v_reverse = 1'b1; v_loop = 1'b1;
    seek(1);
    beats(9, 2);

    // Seek clamp, then stop beating seek in the same cycle.
    v_slow = 1'b0; v_reverse = 1'b0; v_len = W'(10);
    seek(25);
    idle(2);
    cyc(1'b0, 1'b1, 1'b1, W'(3));
    idle(2);

    // Pause at 7, shrink len, resume.
    seek(7);
    v_play = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, '0);
    beats(3, 2);
    v_len = W'(4);
    v_play = 1'b1;
    idle(1);
    beats(3, 2);

    // Asynchronous reset mid-run at beat 5.
    v_len = W'(10);
    seek(5);
    idle(2);
    mid_reset();
    idle(2);
    v_reset = 1'b1;
    idle(1);
    beats(3, 2);

    // Randomised playback.
    for (int i = 0; i < 3000; i++) begin
      logic         be;
      logic         st;
      logic         sk;
      logic [W-1:0] sb;
      if ($urandom_range(0, 49) == 0) v_len     = W'($urandom_range(0, 12));
      if ($urandom_range(0, 29) == 0) v_slow    = ~v_slow;
      if ($urandom_range(0, 29) == 0) v_reverse = ~v_reverse;
      if ($urandom_range(0, 39) == 0) v_loop    = ~v_loop;
      if ($urandom_range(0, 19) == 0) v_play    = ~v_play;
      be = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 99) == 0);
      sk = ($urandom_range(0, 59) == 0);
      sb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 4095))
                                       : W'($urandom_range(0, 14));
      if (i % 1000 == 500) begin
        mid_reset();
        idle(1);
        v_reset = 1'b1;
      end
      cyc(be, st, sk, sb);
    end

    idle(1);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #3;
    check("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/beat_sequencer.md
# beat_sequencer

Parametrised beat-index sequencer for the music playback path: generates the current beat address `ibeat` into the note/score ROM, advancing one position per qualified `beat_en` tick. It extends the original single-mode player counter with configurable width, a run-time track length, a half-speed (slow) prescaler, reverse playback, loop vs. one-shot end behaviour, seek, stop, and wrap/done status pulses. It sits between the beat-rate clock divider (which supplies `beat_en`) and the score ROM address input.

## Interface
- `WIDTH`, 12, bit width of `ibeat`, `len`, `seek_beat`
- `SLOW_DIV`, 2, `beat_en` ticks per step in slow mode; legal range 2..16
- `clk`  in  1  system clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `beat_en`  in  1  single-cycle beat tick from the clock divider
- `play`  in  1  level; 1 = run, 0 = pause
- `slow`  in  1  level; 1 = step every `SLOW_DIV` ticks
- `reverse`  in  1  level; 1 = count down
- `loop`  in  1  level; 1 = wrap at track ends, 0 = stop at ends
- `stop`  in  1  single-cycle; return to beat 0, idle
- `seek_valid`  in  1  single-cycle; load `seek_beat`
- `seek_beat`  in  WIDTH  seek target
- `len`  in  WIDTH  track length in beats; legal beats 0..len-1; `len`=0 treated as 1
- `ibeat`  out  WIDTH  current beat index (registered)
- `playing`  out  1  1 while in RUN (registered)
- `wrap`  out  1  one-cycle pulse on loop wrap
- `done`  out  1  one-cycle pulse on entering DONE

## Operation
- States: IDLE (reset state), RUN, PAUSE, DONE. Reset: state IDLE, `ibeat`=0, prescaler=0, `playing`=0, `wrap`=0, `done`=0.
- Let L = max(`len`,1), LAST = L-1, sampled combinationally every cycle.
- Per-cycle priority: `stop` > `seek_valid` > play/pause transition > step.
- `stop`: `ibeat`←0, prescaler←0, state←IDLE, from any state.
- `seek_valid`: `ibeat`←min(`seek_beat`, LAST), prescaler←0; state←RUN if `play`=1 else PAUSE (valid from every state incl. IDLE, DONE). No step that cycle.
- Transitions: IDLE→RUN on `play`=1; RUN→PAUSE on `play`=0; PAUSE→RUN on `play`=1; DONE holds until `stop` or `seek_valid` (ignores `play`).
- Qualified tick = state RUN and `beat_en`=1 and no stop/seek and `play`=1. With `slow`=0 every qualified tick steps. With `slow`=1, a qualified tick with prescaler=SLOW_DIV-1 steps and clears prescaler; otherwise prescaler+1. Prescaler forced to 0 whenever `slow`=0; held in PAUSE.
- Forward step (`reverse`=0): if `ibeat` < LAST, `ibeat`+1. Else (`ibeat` ≥ LAST, incl. after `len` shrink): `loop`=1 → `ibeat`←0, `wrap`=1; `loop`=0 → `ibeat`←LAST, state←DONE, `done`=1.
- Reverse step: if 0 < `ibeat` ≤ LAST, `ibeat`-1. If `ibeat` > LAST: `ibeat`←LAST (plain step, no pulse). If `ibeat`=0: `loop`=1 → `ibeat`←LAST, `wrap`=1; `loop`=0 → hold 0, state←DONE, `done`=1.
- `len` changes take effect at the next step only; `ibeat` is never clamped outside a step/seek.
- `playing` = registered (next state == RUN).
- All arithmetic in WIDTH bits; LAST computed without underflow via the `len`=0→1 rule.

## Timing
- Step, seek, stop: `ibeat` updates at the rising edge sampling the event; visible the following cycle (1-cycle latency).
- `wrap`/`done` assert in the same cycle the new `ibeat` is visible, for exactly one cycle.
- `playing` changes in the same cycle as the state register.
- Asynchronous reset assertion clears all outputs immediately, mid-step included; first step after release needs a fresh `beat_en`.
- Pause/resume: `play` falling in the same cycle as `beat_en` → no step.

## Test plan
- Forward loop: WIDTH=12, len=4, play=1, loop=1, beat_en every 3 cycles → ibeat 0,1,2,3,0; wrap pulse once coinciding with ibeat=0; playing=1 throughout.
- One-shot end: len=3, loop=0 → ibeat 0,1,2 then holds 2; done pulses once; playing→0; further beat_en and play toggles ignored until seek_valid(seek_beat=0) → RUN, ibeat=0.
- Slow + reverse: SLOW_DIV=2, slow=1, reverse=1, loop=1, len=5, seek to 1 → ibeat changes every 2nd beat_en: 1,0,4,3; wrap at 0→4.
- Seek clamp and priority: len=10, seek_beat=25 → ibeat=9; seek_valid and stop same cycle → ibeat=0, state IDLE, playing=0.
- Pause and len shrink: pause at ibeat=7 with beat_en pulses → holds 7; set len=4, resume forward loop=1 → next step ibeat=0 with wrap.
- Async reset mid-run at ibeat=5 (reset=0 between clock edges) → ibeat=0, all status 0 immediately; release and play=1 → first step to 1 on next beat_en.
